// File: rtl/draw_seq_pkg.sv
// Shared types for the draw-list sequencer: shape codes, packed record layout, FSM states.
package draw_seq_pkg;

  localparam int unsigned CORDW = 16;
  localparam int unsigned CIDXW = 4;
  localparam int unsigned RECW  = 2 + 6 * CORDW + CIDXW;

  typedef enum logic [1:0] {
    SHP_END  = 2'd0,
    SHP_LINE = 2'd1,
    SHP_TRI  = 2'd2,
    SHP_SKIP = 2'd3
  } shape_t;

  // Field order MSB to LSB matches the ROM image layout.
  typedef struct packed {
    shape_t                   typ;
    logic signed [CORDW-1:0]  x0;
    logic signed [CORDW-1:0]  y0;
    logic signed [CORDW-1:0]  x1;
    logic signed [CORDW-1:0]  y1;
    logic signed [CORDW-1:0]  x2;
    logic signed [CORDW-1:0]  y2;
    logic [CIDXW-1:0]         cidx;
  } rec_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StDraw,
    StNext,
    StDone
  } state_t;

endpackage

// File: rtl/draw_pacer.sv
// Output-enable pacer: hold oe low for wait_frames frames, then grant pix_per_frame
// oe cycles per frame (0 means unlimited).
module draw_pacer #(
  parameter int unsigned WAITW = 10,
  parameter int unsigned PACEW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic [WAITW-1:0] wait_frames,
  input  logic [PACEW-1:0] pix_per_frame,
  output logic             oe
);

  logic [WAITW-1:0] wait_q, wait_d;
  logic [PACEW-1:0] budget_q, budget_d;
  logic             active_q, active_d;
  logic             oe_q, oe_d;
  logic             waiting;

  assign waiting = (wait_q < wait_frames);

  always_comb begin
    wait_d   = wait_q;
    active_d = active_q;
    budget_d = budget_q;
    if (frame && waiting) begin
      wait_d = wait_q + WAITW'(1);
    end else if (frame) begin
      // A new frame always reloads; leftover budget is discarded.
      active_d = 1'b1;
      budget_d = pix_per_frame;
    end else if (budget_q != '0) begin
      budget_d = budget_q - PACEW'(1);
    end
    oe_d = active_d && ((pix_per_frame == '0) || (budget_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= '0;
      budget_q <= '0;
      active_q <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      budget_q <= budget_d;
      active_q <= active_d;
      oe_q     <= oe_d;
    end
  end

  assign oe = oe_q;

endmodule

// File: rtl/draw_list_seq.sv
// Walks a shape list in a synchronous ROM and launches the line or triangle engine per
// record, presenting registered coordinates and colour alongside a paced output enable.
module draw_list_seq #(
  parameter int unsigned CORDW = 16,
  parameter int unsigned CIDXW = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WAITW = 10,
  parameter int unsigned PACEW = 16,
  localparam int unsigned ADDRW = $clog2(DEPTH),
  localparam int unsigned RECW  = 2 + 6 * CORDW + CIDXW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    run,
  input  logic                    loop,
  input  logic [WAITW-1:0]        wait_frames,
  input  logic [PACEW-1:0]        pix_per_frame,
  output logic [ADDRW-1:0]        rec_addr,
  input  logic [RECW-1:0]         rec_data,
  output logic signed [CORDW-1:0] x0,
  output logic signed [CORDW-1:0] y0,
  output logic signed [CORDW-1:0] x1,
  output logic signed [CORDW-1:0] y1,
  output logic signed [CORDW-1:0] x2,
  output logic signed [CORDW-1:0] y2,
  output logic [CIDXW-1:0]        cidx,
  output logic                    start_line,
  output logic                    start_tri,
  input  logic                    done_line,
  input  logic                    done_tri,
  output logic                    oe,
  output logic                    busy,
  output logic                    list_done
);

  import draw_seq_pkg::*;

  state_t                  state_q, state_d;
  logic [ADDRW-1:0]        addr_q, addr_d;
  logic                    tri_q, tri_d;
  logic                    load;
  logic                    start_line_q, start_line_d;
  logic                    start_tri_q, start_tri_d;
  logic                    list_done_q, list_done_d;
  logic signed [CORDW-1:0] crd_q [6];
  logic [CIDXW-1:0]        cidx_q;
  shape_t                  rec_type;

  assign rec_type = shape_t'(rec_data[RECW-1 -: 2]);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tri_d        = tri_q;
    load         = 1'b0;
    start_line_d = 1'b0;
    start_tri_d  = 1'b0;
    case (state_q)
      StIdle: begin
        addr_d = '0;
        if (frame && run) state_d = StFetch;
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        load = 1'b1;
        unique case (rec_type)
          SHP_END:  state_d = StDone;
          SHP_SKIP: state_d = StNext;
          SHP_LINE: begin
            start_line_d = 1'b1;
            tri_d        = 1'b0;
            state_d      = StDraw;
          end
          SHP_TRI: begin
            start_tri_d = 1'b1;
            tri_d       = 1'b1;
            state_d     = StDraw;
          end
        endcase
      end
      // Only the engine that was launched can end the shape.
      StDraw: begin
        if (tri_q ? done_tri : done_line) state_d = StNext;
      end
      StNext: begin
        if (addr_q == ADDRW'(DEPTH - 1)) begin
          state_d = StDone;
        end else if (!run) begin
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          addr_d  = addr_q + ADDRW'(1);
          state_d = StFetch;
        end
      end
      StDone: begin
        if (!run) begin
          addr_d  = '0;
          state_d = StIdle;
        end else if (loop && frame) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    list_done_d = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      tri_q        <= 1'b0;
      start_line_q <= 1'b0;
      start_tri_q  <= 1'b0;
      list_done_q  <= 1'b0;
      cidx_q       <= '0;
      for (int i = 0; i < 6; i++) crd_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tri_q        <= tri_d;
      start_line_q <= start_line_d;
      start_tri_q  <= start_tri_d;
      list_done_q  <= list_done_d;
      if (load) begin
        cidx_q <= rec_data[CIDXW-1:0];
        for (int i = 0; i < 6; i++) crd_q[i] <= rec_data[CIDXW + (5 - i) * CORDW +: CORDW];
      end
    end
  end

  draw_pacer #(
    .WAITW (WAITW),
    .PACEW (PACEW)
  ) u_pacer (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame         (frame),
    .wait_frames   (wait_frames),
    .pix_per_frame (pix_per_frame),
    .oe            (oe)
  );

  assign rec_addr   = addr_q;
  assign x0         = crd_q[0];
  assign y0         = crd_q[1];
  assign x1         = crd_q[2];
  assign y1         = crd_q[3];
  assign x2         = crd_q[4];
  assign y2         = crd_q[5];
  assign cidx       = cidx_q;
  assign start_line = start_line_q;
  assign start_tri  = start_tri_q;
  assign list_done  = list_done_q;
  assign busy       = (state_q == StFetch) || (state_q == StLoad) ||
                      (state_q == StDraw)  || (state_q == StNext);

endmodule

// File: tb/tb_draw_list_seq.sv
// Directed bench for draw_list_seq: ROM model, delayed-done engine model, pulse counters.
module tb_draw_list_seq;

  import draw_seq_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned ADDRW = 4;
  localparam int unsigned WAITW = 10;
  localparam int unsigned PACEW = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    frame, run, loop;
  logic [WAITW-1:0]        wait_frames;
  logic [PACEW-1:0]        pix_per_frame;
  logic [ADDRW-1:0]        rec_addr;
  logic [RECW-1:0]         rec_data;
  logic signed [CORDW-1:0] x0, y0, x1, y1, x2, y2;
  logic [CIDXW-1:0]        cidx;
  logic                    start_line, start_tri;
  logic                    done_line, done_tri;
  logic                    oe, busy, list_done;

  logic [RECW-1:0] rom [DEPTH];
  logic            eng_done_line, eng_done_tri, man_done_line;
  int              eng_dly;
  int              line_cnt = 0, tri_cnt = 0;
  int              n_line = 0, n_tri = 0, n_ld = 0, n_oe = 0;
  int              n_chk = 0, n_err = 0;
  int              b_line, b_tri, b_ld, b_oe, b_cap;
  rec_t            cap [$];
  rec_t            cap_r;

  assign done_line = eng_done_line | man_done_line;
  assign done_tri  = eng_done_tri;

  draw_list_seq #(
    .CORDW (CORDW),
    .CIDXW (CIDXW),
    .DEPTH (DEPTH),
    .WAITW (WAITW),
    .PACEW (PACEW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame         (frame),
    .run           (run),
    .loop          (loop),
    .wait_frames   (wait_frames),
    .pix_per_frame (pix_per_frame),
    .rec_addr      (rec_addr),
    .rec_data      (rec_data),
    .x0            (x0),
    .y0            (y0),
    .x1            (x1),
    .y1            (y1),
    .x2            (x2),
    .y2            (y2),
    .cidx          (cidx),
    .start_line    (start_line),
    .start_tri     (start_tri),
    .done_line     (done_line),
    .done_tri      (done_tri),
    .oe            (oe),
    .busy          (busy),
    .list_done     (list_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rec_data <= rom[rec_addr];

  // Engines answer eng_dly cycles after their start; counters sampled mid-cycle.
  always @(negedge clk) begin
    eng_done_line = 1'b0;
    eng_done_tri  = 1'b0;
    if (start_line) line_cnt = eng_dly;
    else if (line_cnt > 0) begin
      line_cnt--;
      if (line_cnt == 0) eng_done_line = 1'b1;
    end
    if (start_tri) tri_cnt = eng_dly;
    else if (tri_cnt > 0) begin
      tri_cnt--;
      if (tri_cnt == 0) eng_done_tri = 1'b1;
    end
    if (start_line) n_line++;
    if (start_tri) n_tri++;
    if (list_done) n_ld++;
    if (oe) n_oe++;
    if (start_line || start_tri) begin
      cap_r.typ  = start_tri ? SHP_TRI : SHP_LINE;
      cap_r.x0   = x0;
      cap_r.y0   = y0;
      cap_r.x1   = x1;
      cap_r.y1   = y1;
      cap_r.x2   = x2;
      cap_r.y2   = y2;
      cap_r.cidx = cidx;
      cap.push_back(cap_r);
    end
  end

  function automatic rec_t mk(input shape_t t, input int a, input int b, input int c,
                              input int d, input int e, input int f, input int ci);
    rec_t r;
    r.typ  = t;
    r.x0   = 16'(a);
    r.y0   = 16'(b);
    r.x1   = 16'(c);
    r.y1   = 16'(d);
    r.x2   = 16'(e);
    r.y2   = 16'(f);
    r.cidx = 4'(ci);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
  endtask

  task automatic wait_ld(input int base, input int max, input string tag);
    int k;
    k = 0;
    while (n_ld == base && k < max) begin
      tick(1);
      k++;
    end
    check(tag, 128'(n_ld != base), 128'(1));
  endtask

  task automatic wait_tri(input int base, input int max, input string tag);
    int k;
    k = 0;
    while (n_tri == base && k < max) begin
      tick(1);
      k++;
    end
    check(tag, 128'(n_tri != base), 128'(1));
  endtask

  task automatic snap();
    b_line = n_line;
    b_tri  = n_tri;
    b_ld   = n_ld;
    b_cap  = cap.size();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame = 1'b0; run = 1'b0; loop = 1'b0;
    wait_frames = '0; pix_per_frame = '0; man_done_line = 1'b0; eng_dly = 10;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    rom[0] = mk(SHP_TRI, 20, 60, 60, 180, 110, 90, 2);
    rom[1] = mk(SHP_TRI, 70, 200, 240, 100, 170, 10, 12);
    tick(2);
    check("rst rec_addr", 128'(rec_addr), 128'(0));
    check("rst x0", 128'(x0), 128'(0));
    check("rst y2", 128'(y2), 128'(0));
    check("rst cidx", 128'(cidx), 128'(0));
    check("rst starts", 128'({start_line, start_tri}), 128'(0));
    check("rst oe", 128'(oe), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst list_done", 128'(list_done), 128'(0));
    #3 rst_n = 1'b1;
    tick(3);
    check("oe before first frame", 128'(oe), 128'(0));

    // Two triangles then END.
    run = 1'b1;
    snap();
    pulse_frame();
    check("t1 fetch busy", 128'(busy), 128'(1));
    check("t1 oe unlimited", 128'(oe), 128'(1));
    tick(1);
    check("t1 no start in load", 128'(start_tri), 128'(0));
    tick(1);
    check("t1 start latency", 128'(start_tri), 128'(1));
    check("t1 x0", 128'(x0), 128'(20));
    check("t1 y1", 128'(y1), 128'(180));
    check("t1 cidx", 128'(cidx), 128'(2));
    tick(1);
    check("t1 start one cycle", 128'(start_tri), 128'(0));
    wait_ld(b_ld, 200, "t1 list_done seen");
    tick(5);
    check("t1 tri starts", 128'(n_tri - b_tri), 128'(2));
    check("t1 list_done pulses", 128'(n_ld - b_ld), 128'(1));
    check("t1 rec_addr", 128'(rec_addr), 128'(2));
    check("t1 idle busy", 128'(busy), 128'(0));
    check("t1 second record", 128'(cap[b_cap+1]),
          128'(mk(SHP_TRI, 70, 200, 240, 100, 170, 10, 12)));

    // LINE, SKIP, TRI, END with a stray done_line during the triangle.
    run = 1'b0;
    tick(1);
    check("t2 idle after run drop", 128'(busy), 128'(0));
    check("t2 idle addr", 128'(rec_addr), 128'(0));
    rom[0] = mk(SHP_LINE, 1, 2, 3, 4, 5, 6, 1);
    rom[1] = mk(SHP_SKIP, 9, 9, 9, 9, 9, 9, 9);
    rom[2] = mk(SHP_TRI, 30, 40, 50, 60, 70, 80, 3);
    rom[3] = '0;
    run = 1'b1;
    snap();
    pulse_frame();
    wait_tri(b_tri, 100, "t2 tri start seen");
    tick(3);
    man_done_line = 1'b1;
    tick(1);
    man_done_line = 1'b0;
    tick(1);
    check("t2 done_line ignored busy", 128'(busy), 128'(1));
    check("t2 done_line ignored addr", 128'(rec_addr), 128'(2));
    wait_ld(b_ld, 200, "t2 list_done seen");
    tick(2);
    check("t2 line starts", 128'(n_line - b_line), 128'(1));
    check("t2 tri starts", 128'(n_tri - b_tri), 128'(1));
    check("t2 line record", 128'(cap[b_cap]), 128'(mk(SHP_LINE, 1, 2, 3, 4, 5, 6, 1)));
    check("t2 tri record", 128'(cap[b_cap+1]), 128'(mk(SHP_TRI, 30, 40, 50, 60, 70, 80, 3)));
    check("t2 rec_addr", 128'(rec_addr), 128'(3));

    // Pacer: 3 wait frames then 5 oe cycles per frame.
    run = 1'b0;
    wait_frames = 10'd3;
    pix_per_frame = 16'd5;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    for (int f = 1; f <= 5; f++) begin
      b_oe = n_oe;
      pulse_frame();
      tick(19);
      check($sformatf("pace frame %0d", f), 128'(n_oe - b_oe), 128'((f <= 3) ? 0 : 5));
    end
    b_oe = n_oe;
    pulse_frame();
    tick(2);
    pulse_frame();
    tick(19);
    check("pace reload", 128'(n_oe - b_oe), 128'(8));
    pix_per_frame = '0;
    tick(1);
    b_oe = n_oe;
    tick(30);
    check("pace unlimited", 128'(n_oe - b_oe), 128'(30));

    // Full list with no END record.
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(SHP_TRI, i, 0, 0, 0, 0, 0, i);
    eng_dly = 3;
    run = 1'b1;
    snap();
    pulse_frame();
    wait_ld(b_ld, 1000, "t4 list_done seen");
    tick(10);
    check("t4 tri starts", 128'(n_tri - b_tri), 128'(16));
    check("t4 rec_addr no wrap", 128'(rec_addr), 128'(15));
    check("t4 list_done pulses", 128'(n_ld - b_ld), 128'(1));
    check("t4 last record", 128'(cap[b_cap+15]), 128'(mk(SHP_TRI, 15, 0, 0, 0, 0, 0, 15)));
    check("t4 busy", 128'(busy), 128'(0));

    // Looping list, one triangle per frame.
    rom[0] = mk(SHP_TRI, 7, 8, 9, 10, 11, 12, 5);
    rom[1] = '0;
    loop = 1'b1;
    snap();
    repeat (3) begin
      pulse_frame();
      tick(29);
    end
    check("t5 loop tri starts", 128'(n_tri - b_tri), 128'(3));
    check("t5 loop list_done", 128'(n_ld - b_ld), 128'(3));
    check("t5 loop record", 128'(cap[b_cap+2]), 128'(mk(SHP_TRI, 7, 8, 9, 10, 11, 12, 5)));

    // Drop run while drawing.
    eng_dly = 10;
    snap();
    pulse_frame();
    tick(4);
    check("t5 mid draw busy", 128'(busy), 128'(1));
    run = 1'b0;
    tick(15);
    check("t5 shape completed", 128'(n_tri - b_tri), 128'(1));
    check("t5 stopped busy", 128'(busy), 128'(0));
    check("t5 no list_done", 128'(n_ld - b_ld), 128'(0));
    check("t5 idle addr", 128'(rec_addr), 128'(0));

    // Asynchronous reset while drawing.
    rom[0] = mk(SHP_SKIP, 1, 1, 1, 1, 1, 1, 1);
    rom[1] = mk(SHP_TRI, 100, 101, 102, 103, 104, 105, 9);
    rom[2] = '0;
    loop = 1'b0;
    run = 1'b1;
    snap();
    pulse_frame();
    wait_tri(b_tri, 100, "t6 tri start seen");
    tick(2);
    check("t6 pre x0", 128'(x0), 128'(100));
    check("t6 pre busy", 128'(busy), 128'(1));
    check("t6 pre oe", 128'(oe), 128'(1));
    check("t6 pre addr", 128'(rec_addr), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    check("t6 async busy", 128'(busy), 128'(0));
    check("t6 async oe", 128'(oe), 128'(0));
    check("t6 async x0", 128'(x0), 128'(0));
    check("t6 async cidx", 128'(cidx), 128'(0));
    check("t6 async addr", 128'(rec_addr), 128'(0));
    check("t6 async start", 128'(start_tri), 128'(0));
    wait_frames = 10'd2;
    #2 rst_n = 1'b1;
    tick(10);
    check("t6 waits for frame", 128'(busy), 128'(0));
    check("t6 no new start", 128'(n_tri - b_tri), 128'(1));
    run = 1'b0;
    pulse_frame();
    check("t6 wait frame 1", 128'(oe), 128'(0));
    tick(3);
    pulse_frame();
    check("t6 wait frame 2", 128'(oe), 128'(0));
    tick(3);
    pulse_frame();
    check("t6 active frame 3", 128'(oe), 128'(1));
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
